// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width and the fetch controller state type.
package HighLevelControl;

    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetchState;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer; the head entry drives the outputs
// combinationally and a flush empties it in one cycle.
module fetch_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc
);

    logic [WIDTH-1:0] r_instr [2];
    logic [WIDTH-1:0] r_pcs [2];
    logic             r_rdPtr;
    logic             r_wrPtr;
    logic [1:0]       r_count;

    // Flush wins over a same-cycle push or pop so a redirect always leaves the buffer empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr[0] <= '0;
            r_instr[1] <= '0;
            r_pcs[0]   <= '0;
            r_pcs[1]   <= '0;
            r_rdPtr    <= 1'b0;
            r_wrPtr    <= 1'b0;
            r_count    <= 2'd0;
        end else if (i_flush) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_instr[r_wrPtr] <= i_instr;
                r_pcs[r_wrPtr]   <= i_pc;
                r_wrPtr          <= ~r_wrPtr;
            end
            if (i_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;
    assign o_instr = r_instr[r_rdPtr];
    assign o_pc    = r_pcs[r_rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tagging, redirect handling with stale-response discard, and a 2-entry decode buffer.
module fetch_unit
    import HighLevelControl::fetchState;
    import HighLevelControl::BOOT;
    import HighLevelControl::RUN;
    import HighLevelControl::FLUSH;
#(
    parameter int                   WORD_SIZE = HighLevelControl::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 IMemReq,
    output logic [WORD_SIZE-1:0] IMemAddr,
    input  logic                 IMemGnt,
    input  logic                 IMemRValid,
    input  logic [WORD_SIZE-1:0] IMemRData,
    input  logic                 PCUpdate,
    input  logic [WORD_SIZE-1:0] PCTarget,
    input  logic                 DecReady,
    output logic                 InstrValid,
    output logic [WORD_SIZE-1:0] Instr,
    output logic [WORD_SIZE-1:0] InstrPC
);

    fetchState            r_state;
    fetchState            w_nextState;
    logic [WORD_SIZE-1:0] r_pc;
    logic [1:0]           r_outstanding;
    logic [1:0]           r_discard;
    logic [WORD_SIZE-1:0] r_tag [2];
    logic                 r_tagWr;
    logic                 r_tagRd;

    logic                 w_bufValid;
    logic [1:0]           w_bufCount;
    logic [2:0]           w_inFlight;
    logic [1:0]           w_discardNext;
    logic                 w_pop;
    logic                 w_rsp;
    logic                 w_credit;
    logic                 w_issue;
    logic                 w_push;

    assign w_pop      = w_bufValid && DecReady;
    assign w_rsp      = IMemRValid && (r_outstanding != 2'd0);
    assign w_inFlight = {1'b0, r_outstanding} + {1'b0, w_bufCount};
    // An entry leaving the buffer this cycle frees its slot, which keeps one fetch per cycle in steady state.
    assign w_credit   = (w_inFlight < 3'd2) || w_pop;

    assign IMemReq       = (r_state == RUN) && !PCUpdate && w_credit;
    assign IMemAddr      = r_pc;
    assign w_issue       = IMemReq && IMemGnt;
    assign w_push        = w_rsp && (r_state == RUN) && !PCUpdate;
    assign w_discardNext = r_outstanding - {1'b0, w_rsp};
    assign InstrValid    = w_bufValid;

    fetch_buffer #(
        .WIDTH (WORD_SIZE)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .i_flush (PCUpdate),
        .i_push  (w_push),
        .i_instr (IMemRData),
        .i_pc    (r_tag[r_tagRd]),
        .i_pop   (w_pop),
        .o_valid (w_bufValid),
        .o_count (w_bufCount),
        .o_instr (Instr),
        .o_pc    (InstrPC)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            BOOT:    w_nextState = RUN;
            RUN:     if (PCUpdate && (w_discardNext != 2'd0)) w_nextState = FLUSH;
            FLUSH:   if (!PCUpdate && (r_discard == {1'b0, w_rsp})) w_nextState = RUN;
            default: w_nextState = BOOT;
        endcase
    end

    // Responses still count down the outstanding total while flushing; the tag queue restarts on every redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
            r_tag[0]      <= '0;
            r_tag[1]      <= '0;
            r_tagWr       <= 1'b0;
            r_tagRd       <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + {1'b0, w_issue} - {1'b0, w_rsp};
            if (PCUpdate) begin
                r_pc      <= PCTarget & ~WORD_SIZE'(3);
                r_discard <= w_discardNext;
                r_tagWr   <= 1'b0;
                r_tagRd   <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_pc           <= r_pc + WORD_SIZE'(4);
                    r_tag[r_tagWr] <= r_pc;
                    r_tagWr        <= ~r_tagWr;
                end
                if (w_push) begin
                    r_tagRd <= ~r_tagRd;
                end
                if ((r_state == FLUSH) && w_rsp) begin
                    r_discard <= r_discard - 2'd1;
                end
            end
        end
    end

    a_noOverflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (w_bufCount == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/stall/redirect/reset steps,
// then randomized traffic checked against an issue/deliver stream model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        PCUpdate;
    logic [31:0] PCTarget;
    logic        DecReady;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          drainStart;
    logic [31:0] memQ [$];
    logic [31:0] expIssue;
    logic [31:0] expDeliver;
    logic        prevHeld;
    logic [31:0] prevAddr;
    logic        lastReq;
    logic        lastValid;
    logic [31:0] lastAddr;
    logic [31:0] lastPC;
    logic        seen;
    logic [31:0] randTarget;

    always #5 clk = ~clk;

    fetch_unit #(
        .WORD_SIZE (32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemGnt    (IMemGnt),
        .IMemRValid (IMemRValid),
        .IMemRData  (IMemRData),
        .PCUpdate   (PCUpdate),
        .PCTarget   (PCTarget),
        .DecReady   (DecReady),
        .InstrValid (InstrValid),
        .Instr      (Instr),
        .InstrPC    (InstrPC)
    );

    // Memory contents are a fixed scramble of the address, so every word identifies its own PC.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req", 32'(IMemReq), 32'd0);
        checkOutput("rst_addr", IMemAddr, RESET_PC);
        checkOutput("rst_valid", 32'(InstrValid), 32'd0);
        checkOutput("rst_instr", Instr, 32'd0);
        checkOutput("rst_pc", InstrPC, 32'd0);
    endtask

    // Asserts reset mid-cycle, checks outputs immediately, and returns with reset
    // released just after a rising edge so the next cycle is the BOOT cycle.
    task automatic startReset();
        reset      = 1'b1;
        IMemGnt    = 1'b0;
        IMemRValid = 1'b0;
        IMemRData  = 32'd0;
        PCUpdate   = 1'b0;
        PCTarget   = 32'd0;
        DecReady   = 1'b0;
        #1;
        checkResetOutputs();
        memQ.delete();
        expIssue   = RESET_PC;
        expDeliver = RESET_PC;
        prevHeld   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, sample outputs, check them against the stream
    // model, advance the model, then wait for the rising edge.
    task automatic applyStimulus(input logic gnt, input logic dec, input logic rspEn,
                                 input logic upd, input logic [31:0] target);
        IMemGnt  = gnt;
        DecReady = dec;
        PCUpdate = upd;
        PCTarget = target;
        if (rspEn && (memQ.size() > 0)) begin
            IMemRValid = 1'b1;
            IMemRData  = memWord(memQ[0]);
        end else begin
            IMemRValid = 1'b0;
            IMemRData  = $urandom;
        end
        #1;
        lastReq   = IMemReq;
        lastAddr  = IMemAddr;
        lastValid = InstrValid;
        lastPC    = InstrPC;

        if (prevHeld && !upd) begin
            checkOutput("req_held", 32'(IMemReq), 32'd1);
            checkOutput("addr_held", IMemAddr, prevAddr);
        end
        if (upd) checkOutput("req_on_redirect", 32'(IMemReq), 32'd0);
        if (IMemReq) checkOutput("addr_align", 32'(IMemAddr[1:0]), 32'd0);
        checkOutput("live_bound", 32'((expIssue - expDeliver) > 32'd8), 32'd0);

        if (IMemRValid) void'(memQ.pop_front());
        if (IMemReq && gnt) begin
            if (!upd) begin
                checkOutput("issue_addr", IMemAddr, expIssue);
                checkOutput("outstanding_cap", 32'(memQ.size() < 2), 32'd1);
                expIssue = expIssue + 32'd4;
            end
            memQ.push_back(IMemAddr);
        end
        if (InstrValid && dec) begin
            checkOutput("instr_pc", InstrPC, expDeliver);
            checkOutput("instr_word", Instr, memWord(expDeliver));
            expDeliver = expDeliver + 32'd4;
            delivered++;
        end
        if (upd) begin
            expIssue   = target & ~32'd3;
            expDeliver = expIssue;
        end
        prevHeld = IMemReq && !gnt && !upd;
        prevAddr = IMemAddr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state and first-fetch latency with an ideal 1-cycle memory.
        startReset();
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("boot_req", 32'(lastReq), 32'd0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("c1_req", 32'(lastReq), 32'd1);
        checkOutput("c1_addr", lastAddr, 32'h0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("c2_addr", lastAddr, 32'h4);
        checkOutput("c2_valid", 32'(lastValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("c3_valid", 32'(lastValid), 32'd1);
        checkOutput("c3_pc", lastPC, 32'h0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("c4_pc", lastPC, 32'h4);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("c5_pc", lastPC, 32'h8);

        // Decode stall: requests stop once two entries are in flight or buffered.
        repeat (5) applyStimulus(1, 0, 1, 0, 0);
        checkOutput("stall_full_req", 32'(lastReq), 32'd0);
        repeat (10) applyStimulus(1, 1, 1, 0, 0);

        // Grant withheld: the third request holds address 0x8 until accepted.
        startReset();
        repeat (3) applyStimulus(1, 1, 1, 0, 0);
        repeat (3) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput("gnt_stall_req", 32'(lastReq), 32'd1);
            checkOutput("gnt_stall_addr", lastAddr, 32'h8);
        end
        repeat (4) applyStimulus(1, 1, 1, 0, 0);

        // Redirect with two responses outstanding: both dropped, then fetch from 0x100.
        startReset();
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 32'h100);
        repeat (2) begin
            applyStimulus(1, 1, 1, 0, 0);
            checkOutput("flush_req", 32'(lastReq), 32'd0);
            checkOutput("flush_valid", 32'(lastValid), 32'd0);
        end
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("post_flush_req", 32'(lastReq), 32'd1);
        checkOutput("post_flush_addr", lastAddr, 32'h100);
        seen = 1'b0;
        for (int i = 0; (i < 6) && !seen; i++) begin
            applyStimulus(1, 1, 1, 0, 0);
            if (lastValid) begin
                seen = 1'b1;
                checkOutput("redirect_first_pc", lastPC, 32'h100);
            end
        end
        if (!seen) checkOutput("redirect_first_pc_timeout", 32'(lastValid), 32'd1);

        // Redirect to an unaligned target coinciding with a pop and a response.
        startReset();
        repeat (4) applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 1, 32'h203);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("unaligned_valid", 32'(lastValid), 32'd0);
        checkOutput("unaligned_req", 32'(lastReq), 32'd1);
        checkOutput("unaligned_addr", lastAddr, 32'h200);
        repeat (3) applyStimulus(1, 1, 1, 0, 0);

        // Reset asserted while flushing stale responses.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 32'h40);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("pre_reset_flush_req", 32'(lastReq), 32'd0);
        startReset();
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("restart_addr", lastAddr, RESET_PC);
        checkOutput("restart_req", 32'(lastReq), 32'd1);

        // Randomized traffic, including redirects near the top of the address space.
        for (int i = 0; i < 3000; i++) begin
            randTarget = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, randTarget);
        end

        // Drain with an ideal memory and consumer: fetch must keep making progress.
        drainStart = delivered;
        repeat (20) applyStimulus(1, 1, 1, 0, 0);
        checkOutput("drain_progress", 32'((delivered - drainStart) >= 10), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
